// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the two-port memory responder: vc mem message field
// offsets, type codes, per-port FSM state and byte-lane helpers.
package riscv_mem_responder_pkg;

    localparam int REQ_MSG_W    = 67;
    localparam int RESP_MSG_W   = 35;
    localparam int REQ_TYPE_BIT = 66;
    localparam int REQ_ADDR_MSB = 65;
    localparam int REQ_ADDR_LSB = 34;
    localparam int LEN_MSB      = 33;
    localparam int LEN_LSB      = 32;
    localparam int DATA_MSB     = 31;
    localparam int DATA_LSB     = 0;

    localparam logic TYPE_READ  = 1'b0;
    localparam logic TYPE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DELAY = 2'd2,
        ST_RESP  = 2'd3
    } port_state_e;

    // Lanes covered by an access; anything past byte 3 is dropped, never wrapped.
    function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] len);
        logic [2:0] lo;
        logic [2:0] hi;
        logic [3:0] m;
        lo = {1'b0, off};
        hi = lo + ((len == 2'd0) ? 3'd4 : {1'b0, len});
        for (int b = 0; b < 4; b++) begin
            m[b] = (3'(b) >= lo) && (3'(b) < hi);
        end
        return m;
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/riscv_mem_responder_port.sv
// One request/response port: accepts a request, waits for an array grant,
// counts out the access latency and holds the response until consumed.
module riscv_mem_responder_port
    import riscv_mem_responder_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_val_i,
    output logic                  req_rdy_o,
    input  logic [REQ_MSG_W-1:0]  req_msg_i,
    output logic                  resp_val_o,
    input  logic                  resp_rdy_i,
    output logic [RESP_MSG_W-1:0] resp_msg_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [REQ_MSG_W-1:0]  mem_msg_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    port_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [REQ_MSG_W-1:0]    req_msg_q;
    logic [RESP_MSG_W-1:0]   resp_msg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_val_i)     state_d = ST_PEND;
            ST_PEND:  if (mem_gnt_i)     state_d = (LATENCY == 0) ? ST_RESP : ST_DELAY;
            ST_DELAY: if (cnt_q == '0)   state_d = ST_RESP;
            ST_RESP:  if (resp_rdy_i)    state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_rdy_o  = 1'b0;
        resp_val_o = 1'b0;
        mem_req_o  = 1'b0;
        case (state_q)
            ST_IDLE: req_rdy_o  = 1'b1;
            ST_PEND: mem_req_o  = 1'b1;
            ST_RESP: resp_val_o = 1'b1;
            default: ;
        endcase
    end

    // Response is captured at grant time so it stays stable through any backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_msg_q  <= '0;
            resp_msg_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (state_q == ST_IDLE && req_val_i) begin
                req_msg_q <= req_msg_i;
            end
            if (state_q == ST_PEND && mem_gnt_i) begin
                resp_msg_q <= {req_msg_q[REQ_TYPE_BIT], req_msg_q[LEN_MSB:LEN_LSB], mem_rdata_i};
                cnt_q      <= CNT_INIT;
            end else if (state_q == ST_DELAY && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign mem_msg_o  = req_msg_q;
    assign resp_msg_o = resp_msg_q;

endmodule

// File: rtl/riscv_mem_responder_2port.sv
// Two-port memory responder: shared single-ported word array, round-robin
// arbitration between the ports, byte-lane extract/merge.
module riscv_mem_responder_2port
    import riscv_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cache0req_val,
    output logic                  cache0req_rdy,
    input  logic [REQ_MSG_W-1:0]  cache0req_msg,
    output logic                  cache0resp_val,
    input  logic                  cache0resp_rdy,
    output logic [RESP_MSG_W-1:0] cache0resp_msg,
    input  logic                  cache1req_val,
    output logic                  cache1req_rdy,
    input  logic [REQ_MSG_W-1:0]  cache1req_msg,
    output logic                  cache1resp_val,
    input  logic                  cache1resp_rdy,
    output logic [RESP_MSG_W-1:0] cache1resp_msg
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]          mem_q [MEM_WORDS];
    logic                 pend0, pend1, gnt0, gnt1;
    logic                 rr_q, rr_d;
    logic [REQ_MSG_W-1:0] pmsg0, pmsg1, acc_msg;
    logic [31:0]          acc_addr, acc_word, acc_rdata, wdata_sh, bmask;
    logic [AW-1:0]        acc_idx;
    logic [3:0]           acc_be;
    logic [4:0]           acc_sh;
    logic                 acc_wr;
    logic                 unused_addr_bits;

    riscv_mem_responder_port #(.LATENCY(LATENCY)) u_port0 (
        .clk_i(clk), .rst_ni(reset),
        .req_val_i(cache0req_val), .req_rdy_o(cache0req_rdy), .req_msg_i(cache0req_msg),
        .resp_val_o(cache0resp_val), .resp_rdy_i(cache0resp_rdy), .resp_msg_o(cache0resp_msg),
        .mem_req_o(pend0), .mem_gnt_i(gnt0), .mem_msg_o(pmsg0), .mem_rdata_i(acc_rdata)
    );

    riscv_mem_responder_port #(.LATENCY(LATENCY)) u_port1 (
        .clk_i(clk), .rst_ni(reset),
        .req_val_i(cache1req_val), .req_rdy_o(cache1req_rdy), .req_msg_i(cache1req_msg),
        .resp_val_o(cache1resp_val), .resp_rdy_i(cache1resp_rdy), .resp_msg_o(cache1resp_msg),
        .mem_req_o(pend1), .mem_gnt_i(gnt1), .mem_msg_o(pmsg1), .mem_rdata_i(acc_rdata)
    );

    // rr_q names the port that wins the next contested cycle.
    always_comb begin
        gnt0 = pend0 && (!pend1 || !rr_q);
        gnt1 = pend1 && (!pend0 ||  rr_q);
        rr_d = (pend0 && pend1) ? ~rr_q : rr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        acc_msg   = gnt1 ? pmsg1 : pmsg0;
        acc_addr  = acc_msg[REQ_ADDR_MSB:REQ_ADDR_LSB];
        acc_idx   = acc_addr[AW+1:2];
        acc_wr    = (acc_msg[REQ_TYPE_BIT] == TYPE_WRITE);
        acc_be    = lane_mask(acc_addr[1:0], acc_msg[LEN_MSB:LEN_LSB]);
        bmask     = expand_mask(acc_be);
        acc_sh    = {acc_addr[1:0], 3'b000};
        acc_word  = mem_q[acc_idx];
        wdata_sh  = acc_msg[DATA_MSB:DATA_LSB] << acc_sh;
        acc_rdata = acc_wr ? 32'h0 : ((acc_word & bmask) >> acc_sh);
    end

    assign unused_addr_bits = ^acc_addr[31:AW+2];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if ((gnt0 || gnt1) && acc_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder_2port.sv
// Directed and randomized checks of the two-port memory responder against a
// byte-level reference memory kept in the bench.
module tb_riscv_mem_responder_2port;

    localparam int MW = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rq_val, rq_rdy, rs_val, rs_rdy;
    logic [66:0] rq_msg [4];
    logic [34:0] rs_msg [4];

    int total = 0;
    int bad   = 0;
    int rr_exp;
    logic [31:0] mem_m [MW];

    always #5 clk = ~clk;

    riscv_mem_responder_2port #(.MEM_WORDS(MW), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .cache0req_val(rq_val[0]), .cache0req_rdy(rq_rdy[0]), .cache0req_msg(rq_msg[0]),
        .cache0resp_val(rs_val[0]), .cache0resp_rdy(rs_rdy[0]), .cache0resp_msg(rs_msg[0]),
        .cache1req_val(rq_val[1]), .cache1req_rdy(rq_rdy[1]), .cache1req_msg(rq_msg[1]),
        .cache1resp_val(rs_val[1]), .cache1resp_rdy(rs_rdy[1]), .cache1resp_msg(rs_msg[1])
    );

    riscv_mem_responder_2port #(.MEM_WORDS(MW), .LATENCY(0)) dut_z (
        .clk(clk), .reset(reset),
        .cache0req_val(rq_val[2]), .cache0req_rdy(rq_rdy[2]), .cache0req_msg(rq_msg[2]),
        .cache0resp_val(rs_val[2]), .cache0resp_rdy(rs_rdy[2]), .cache0resp_msg(rs_msg[2]),
        .cache1req_val(rq_val[3]), .cache1req_rdy(rq_rdy[3]), .cache1req_msg(rq_msg[3]),
        .cache1resp_val(rs_val[3]), .cache1resp_rdy(rs_rdy[3]), .cache1resp_msg(rs_msg[3])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte lanes addressed from addr%4, len 0 means four bytes, lanes past byte 3 dropped.
    function automatic logic [34:0] model(input bit typ, input logic [31:0] addr,
                                          input logic [1:0] len, input logic [31:0] data);
        int idx, off, n;
        logic [31:0] r;
        idx = int'((addr >> 2) % MW);
        off = int'(addr % 4);
        n   = (len == 2'd0) ? 4 : int'(len);
        r   = '0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 4) begin
                if (typ) mem_m[idx][8*(off+i) +: 8] = data[8*i +: 8];
                else     r[8*i +: 8] = mem_m[idx][8*(off+i) +: 8];
            end
        end
        return {typ, len, typ ? 32'h0 : r};
    endfunction

    task automatic txn(input int p, input bit typ, input logic [31:0] addr, input logic [1:0] len,
                       input logic [31:0] data, output logic [34:0] msg, output int lat);
        int w;
        rq_msg[p] = {typ, addr, len, data};
        rq_val[p] = 1'b1;
        w = 0;
        while (!rq_rdy[p] && w < 50) begin tick(); w++; end
        chk("accept_bound", 64'(w < 50), 64'(1));
        tick();
        rq_val[p] = 1'b0;
        lat = 0;
        while (!rs_val[p] && lat < 50) begin tick(); lat++; end
        msg = rs_msg[p];
        tick();
    endtask

    task automatic both(input logic [66:0] m0, input logic [66:0] m1,
                        output logic [34:0] r0, output logic [34:0] r1,
                        output int l0, output int l1);
        chk("both_rdy", 64'(rq_rdy[1:0]), 64'(2'b11));
        rq_msg[0] = m0; rq_msg[1] = m1;
        rq_val[0] = 1'b1; rq_val[1] = 1'b1;
        tick();
        rq_val[0] = 1'b0; rq_val[1] = 1'b0;
        l0 = -1; l1 = -1; r0 = '0; r1 = '0;
        for (int c = 0; c < 30; c++) begin
            if (rs_val[0] && l0 < 0) begin l0 = c; r0 = rs_msg[0]; end
            if (rs_val[1] && l1 < 0) begin l1 = c; r1 = rs_msg[1]; end
            if (l0 >= 0 && l1 >= 0) break;
            tick();
        end
        tick();
    endtask

    initial begin
        logic [34:0] m, e, r0, r1, e0, e1, held, p1m;
        logic [31:0] a, d;
        logic [1:0]  ln;
        bit          ty;
        int          lat, l0, l1, p, cnt;
        bit          seen;

        reset  = 1'b0;
        rq_val = '0;
        rs_rdy = 4'b1111;
        for (int i = 0; i < 4; i++) rq_msg[i] = '0;
        tick(); tick();
        reset = 1'b1;
        rr_exp = 0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_req_rdy", 64'(rq_rdy[i]), 64'(1));
            chk("rst_resp_val", 64'(rs_val[i]), 64'(0));
            chk("rst_resp_msg", 64'(rs_msg[i]), 64'(0));
        end

        // Fill the whole array through the ports so every model word is defined.
        for (int i = 0; i < MW; i++) begin
            d = $urandom;
            e = model(1'b1, 32'(i * 4), 2'd0, d);
            txn(i % 2, 1'b1, 32'(i * 4), 2'd0, d, m, lat);
            chk("init_wr", 64'(m), 64'(e));
        end

        // Test 1: full-word read with latency 3 from accept.
        e = model(1'b1, 32'h40, 2'd0, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h40, 2'd0, 32'hDEADBEEF, m, lat);
        e = model(1'b0, 32'h40, 2'd0, 32'h0);
        txn(0, 1'b0, 32'h40, 2'd0, 32'h0, m, lat);
        chk("t1_msg", 64'(m), 64'({1'b0, 2'd0, 32'hDEADBEEF}));
        chk("t1_lat", 64'(lat), 64'(3));

        // Test 2: single-byte write then word read on port 1.
        e = model(1'b1, 32'h41, 2'd1, 32'hAA);
        txn(1, 1'b1, 32'h41, 2'd1, 32'hAA, m, lat);
        chk("t2_wr_msg", 64'(m), 64'({1'b1, 2'd1, 32'h0}));
        e = model(1'b0, 32'h40, 2'd0, 32'h0);
        txn(1, 1'b0, 32'h40, 2'd0, 32'h0, m, lat);
        chk("t2_rd_msg", 64'(m), 64'({1'b0, 2'd0, 32'hDEADAAEF}));
        txn(0, 1'b0, 32'h43, 2'd0, 32'h0, m, lat);
        chk("t2_drop_lanes", 64'(m), 64'({1'b0, 2'd0, 32'h000000DE}));

        // Test 3: contested reads alternate who goes first.
        for (int r = 0; r < 2; r++) begin
            e0 = model(1'b0, 32'h0, 2'd0, 32'h0);
            e1 = model(1'b0, 32'h4, 2'd0, 32'h0);
            both({1'b0, 32'h0, 2'd0, 32'h0}, {1'b0, 32'h4, 2'd0, 32'h0}, r0, r1, l0, l1);
            chk("t3_lat0", 64'(l0), 64'((rr_exp == 0) ? 3 : 4));
            chk("t3_lat1", 64'(l1), 64'((rr_exp == 1) ? 3 : 4));
            chk("t3_msg0", 64'(r0), 64'(e0));
            chk("t3_msg1", 64'(r1), 64'(e1));
            rr_exp ^= 1;
        end

        // Same-word write/read race: whoever is granted first decides what the read sees.
        for (int r = 0; r < 2; r++) begin
            d = $urandom;
            if (rr_exp == 0) begin
                e0 = model(1'b1, 32'h14, 2'd0, d);
                e1 = model(1'b0, 32'h14, 2'd0, 32'h0);
            end else begin
                e1 = model(1'b0, 32'h14, 2'd0, 32'h0);
                e0 = model(1'b1, 32'h14, 2'd0, d);
            end
            both({1'b1, 32'h14, 2'd0, d}, {1'b0, 32'h14, 2'd0, 32'h0}, r0, r1, l0, l1);
            chk("race_wr", 64'(r0), 64'(e0));
            chk("race_rd", 64'(r1), 64'(e1));
            rr_exp ^= 1;
        end

        // Test 4: port 0 backpressure while port 1 keeps working.
        rs_rdy[0] = 1'b0;
        e = model(1'b0, 32'h40, 2'd0, 32'h0);
        rq_msg[0] = {1'b0, 32'h40, 2'd0, 32'h0};
        rq_val[0] = 1'b1;
        tick();
        rq_val[0] = 1'b0;
        cnt = 0;
        while (!rs_val[0] && cnt < 50) begin tick(); cnt++; end
        held = rs_msg[0];
        chk("t4_msg", 64'(held), 64'(e));
        e1 = model(1'b0, 32'h4, 2'd0, 32'h0);
        rq_msg[1] = {1'b0, 32'h4, 2'd0, 32'h0};
        rq_val[1] = 1'b1;
        seen = 1'b0;
        p1m  = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) rq_val[1] = 1'b0;
            chk("t4_hold_val", 64'(rs_val[0]), 64'(1));
            chk("t4_hold_msg", 64'(rs_msg[0]), 64'(held));
            chk("t4_req_rdy0", 64'(rq_rdy[0]), 64'(0));
            if (rs_val[1] && !seen) begin seen = 1'b1; p1m = rs_msg[1]; end
        end
        chk("t4_p1_seen", 64'(seen), 64'(1));
        chk("t4_p1_msg", 64'(p1m), 64'(e1));
        rs_rdy[0] = 1'b1;
        tick();
        chk("t4_released", 64'(rs_val[0]), 64'(0));
        chk("t4_rdy_back", 64'(rq_rdy[0]), 64'(1));

        // Randomized single transactions across both ports, with address wrap.
        for (int i = 0; i < 80; i++) begin
            p  = int'($urandom_range(0, 1));
            ty = 1'($urandom_range(0, 1));
            a  = $urandom;
            ln = 2'($urandom_range(0, 3));
            d  = $urandom;
            e  = model(ty, a, ln, d);
            txn(p, ty, a, ln, d, m, lat);
            chk("rand_msg", 64'(m), 64'(e));
            chk("rand_lat", 64'(lat), 64'(3));
        end

        // Test 5: reset while port 0 is counting down latency.
        rq_msg[0] = {1'b0, 32'h40, 2'd0, 32'h0};
        rq_val[0] = 1'b1;
        tick();
        rq_val[0] = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_val_drop", 64'(rs_val[0]), 64'(0));
        chk("t5_msg_clr", 64'(rs_msg[0]), 64'(0));
        tick(); tick();
        reset = 1'b1;
        rr_exp = 0;
        chk("t5_rdy_after", 64'(rq_rdy[0]), 64'(1));
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rs_val[0]) cnt++;
        end
        chk("t5_no_resp", 64'(cnt), 64'(0));
        e0 = model(1'b0, 32'h0, 2'd0, 32'h0);
        e1 = model(1'b0, 32'h4, 2'd0, 32'h0);
        both({1'b0, 32'h0, 2'd0, 32'h0}, {1'b0, 32'h4, 2'd0, 32'h0}, r0, r1, l0, l1);
        chk("t5_rr_lat0", 64'(l0), 64'(3));
        chk("t5_rr_lat1", 64'(l1), 64'(4));
        chk("t5_persist0", 64'(r0), 64'(e0));
        chk("t5_persist1", 64'(r1), 64'(e1));

        // Test 6: zero-latency build.
        txn(2, 1'b1, 32'h40, 2'd0, 32'h11223344, m, lat);
        chk("t6_wr_msg", 64'(m), 64'({1'b1, 2'd0, 32'h0}));
        txn(2, 1'b0, 32'h42, 2'd2, 32'h0, m, lat);
        chk("t6_rd_msg", 64'(m), 64'({1'b0, 2'd2, 32'h00001122}));
        chk("t6_lat", 64'(lat), 64'(1));
        chk("t6_idle_p1_rdy", 64'(rq_rdy[3]), 64'(1));
        chk("t6_idle_p1_val", 64'(rs_val[3]), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
